// File: rtl/weight_config_loader_pkg.sv
// Shared definitions for the weight configuration loader: FSM states, header
// field positions and the width of the configuration port.
package weight_config_loader_pkg;

    typedef enum logic [1:0] {
        StHdr0,
        StHdr1,
        StData,
        StDone
    } state_e;

    // Header word 0 carries the target layer in the upper half, neuron in the lower.
    localparam int unsigned LAYER_MSB  = 31;
    localparam int unsigned LAYER_LSB  = 16;
    localparam int unsigned NEURON_MSB = 15;
    localparam int unsigned NEURON_LSB = 0;

    localparam int unsigned LAYER_W  = LAYER_MSB - LAYER_LSB + 1;
    localparam int unsigned NEURON_W = NEURON_MSB - NEURON_LSB + 1;

    localparam int unsigned CFG_WIDTH = 32;

endpackage

// File: rtl/weight_config_loader.sv
// Parses a framed host word stream (two header words, then payload) and emits one
// registered weight write per payload word, tagged with the frame's layer/neuron.
module weight_config_loader
    import weight_config_loader_pkg::*;
#(
    parameter int unsigned data_bits   = 16,
    parameter int unsigned num_weights = 784,
    parameter int unsigned cnt_bits    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 weight_valid,
    output logic [CFG_WIDTH-1:0] weight_value,
    output logic [CFG_WIDTH-1:0] config_layer_no,
    output logic [CFG_WIDTH-1:0] config_neuron_no,
    output logic                 load_done,
    output logic                 load_err,
    output logic [cnt_bits-1:0]  weight_index
);

    localparam logic [cnt_bits-1:0] MaxCount = cnt_bits'(num_weights);

    state_e                state_q;
    logic [LAYER_W-1:0]    layer_q;
    logic [NEURON_W-1:0]   neuron_q;
    logic [cnt_bits-1:0]   count_q;
    logic [cnt_bits-1:0]   index_q;

    logic                  xfer;
    logic [cnt_bits-1:0]   hdr_count;
    logic                  count_bad;
    logic                  last_word;
    logic [CFG_WIDTH-1:0]  weight_ext;

    // Only the DONE cycle refuses input; it doubles as the load_done cycle.
    assign s_ready   = (state_q != StDone);
    assign xfer      = s_valid && s_ready;
    assign hdr_count = s_data[cnt_bits-1:0];
    assign count_bad = (hdr_count == '0) || (hdr_count > MaxCount);
    assign last_word = (index_q == (count_q - cnt_bits'(1)));

    always_comb begin
        weight_ext = {{(CFG_WIDTH - data_bits){s_data[data_bits-1]}}, s_data[data_bits-1:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StHdr0;
            layer_q          <= '0;
            neuron_q         <= '0;
            count_q          <= '0;
            index_q          <= '0;
            weight_valid     <= 1'b0;
            weight_value     <= '0;
            config_layer_no  <= '0;
            config_neuron_no <= '0;
            load_done        <= 1'b0;
            load_err         <= 1'b0;
            weight_index     <= '0;
        end else begin
            weight_valid <= 1'b0;
            load_done    <= 1'b0;
            unique case (state_q)
                StHdr0: begin
                    if (xfer) begin
                        layer_q  <= s_data[LAYER_MSB:LAYER_LSB];
                        neuron_q <= s_data[NEURON_MSB:NEURON_LSB];
                        state_q  <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        count_q <= hdr_count;
                        if (count_bad) begin
                            load_err <= 1'b1;
                            state_q  <= StHdr0;
                        end else begin
                            index_q <= '0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        weight_valid     <= 1'b1;
                        weight_value     <= weight_ext;
                        config_layer_no  <= CFG_WIDTH'(layer_q);
                        config_neuron_no <= CFG_WIDTH'(neuron_q);
                        weight_index     <= index_q;
                        index_q          <= index_q + cnt_bits'(1);
                        if (last_word) begin
                            load_done <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StHdr0;
                end
                default: begin
                    state_q <= StHdr0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_config_loader.sv
// Directed bench for weight_config_loader: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares each weight_valid beat.
module tb_weight_config_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        weight_valid;
    logic [31:0] weight_value;
    logic [31:0] config_layer_no;
    logic [31:0] config_neuron_no;
    logic        load_done;
    logic        load_err;
    logic [15:0] weight_index;

    typedef struct {
        logic [31:0] val;
        logic [31:0] layer;
        logic [31:0] neuron;
        logic [15:0] idx;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors = 0;

    weight_config_loader #(
        .data_bits  (16),
        .num_weights(784),
        .cnt_bits   (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .weight_valid    (weight_valid),
        .weight_value    (weight_value),
        .config_layer_no (config_layer_no),
        .config_neuron_no(config_neuron_no),
        .load_done       (load_done),
        .load_err        (load_err),
        .weight_index    (weight_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Holds s_valid until a transfer edge; returns the number of edges it took.
    task automatic send(input logic [31:0] d, output int edges);
        logic rdy;
        edges   = 0;
        s_data  = d;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            edges++;
            if (rdy) break;
            if (edges >= 200) begin
                vectors++;
                errors++;
                $display("FAIL send_timeout: got no transfer in %0d cycles, want accept", edges);
                break;
            end
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic put(input logic [31:0] d);
        int e;
        send(d, e);
    endtask

    task automatic wr(input logic [31:0] d, input logic [31:0] val, input logic [31:0] lay,
                      input logic [31:0] neu, input int idx, input logic done);
        exp_t e;
        e.val    = val;
        e.layer  = lay;
        e.neuron = neu;
        e.idx    = 16'(idx);
        e.done   = done;
        exp_q.push_back(e);
        put(d);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (weight_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_write: got write idx %0d val %h, want none",
                             weight_index, weight_value);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("weight_value", weight_value, mon_e.val);
                    chk("config_layer_no", config_layer_no, mon_e.layer);
                    chk("config_neuron_no", config_neuron_no, mon_e.neuron);
                    chk("weight_index", 32'(weight_index), 32'(mon_e.idx));
                    chk("load_done_on_write", 32'(load_done), 32'(mon_e.done));
                end
            end else if (load_done) begin
                vectors++;
                errors++;
                $display("FAIL stray_load_done: got 1 without write, want 0");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_weight_valid", 32'(weight_valid), 32'h0);
        chk("rst_weight_value", weight_value, 32'h0);
        chk("rst_layer", config_layer_no, 32'h0);
        chk("rst_neuron", config_neuron_no, 32'h0);
        chk("rst_load_done", 32'(load_done), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);
        chk("rst_index", 32'(weight_index), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        reset_n = 1'b1;
        idle(1);

        // Basic frame, continuous s_valid; upper payload bits must be ignored
        put(32'h0001_0003);
        put(32'd4);
        wr(32'hABCD_0001, 32'h0000_0001, 32'd1, 32'd3, 0, 1'b0);
        wr(32'h0000_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd3, 1, 1'b0);
        wr(32'h0000_7FFF, 32'h0000_7FFF, 32'd1, 32'd3, 2, 1'b0);
        wr(32'h1234_8000, 32'hFFFF_8000, 32'd1, 32'd3, 3, 1'b1);
        chk("done_s_ready", 32'(s_ready), 32'h0);
        chk("done_pulse", 32'(load_done), 32'h1);
        idle(1);
        chk("after_done_s_ready", 32'(s_ready), 32'h1);

        // Same frame with a 3-cycle s_valid gap after the second weight
        put(32'h0001_0003);
        put(32'd4);
        wr(32'h0000_0001, 32'h0000_0001, 32'd1, 32'd3, 0, 1'b0);
        wr(32'h0000_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd3, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("gap_weight_valid", 32'(weight_valid), 32'h0);
            chk("gap_value_held", weight_value, 32'hFFFF_FFFF);
            chk("gap_layer_held", config_layer_no, 32'd1);
        end
        wr(32'h0000_7FFF, 32'h0000_7FFF, 32'd1, 32'd3, 2, 1'b0);
        wr(32'h0000_8000, 32'hFFFF_8000, 32'd1, 32'd3, 3, 1'b1);
        idle(1);

        // Illegal counts, then a legal frame
        put(32'h0005_0006);
        put(32'd0);
        chk("err_after_count0", 32'(load_err), 32'h1);
        put(32'h0005_0006);
        put(32'd785);
        chk("err_after_count785", 32'(load_err), 32'h1);
        put(32'h0007_0008);
        put(32'd2);
        wr(32'h0000_1234, 32'h0000_1234, 32'd7, 32'd8, 0, 1'b0);
        wr(32'h0000_9000, 32'hFFFF_9000, 32'd7, 32'd8, 1, 1'b1);
        idle(1);
        chk("err_sticky", 32'(load_err), 32'h1);

        // Back-to-back frames: second HDR0 stalls only through the DONE cycle
        put(32'h0000_0000);
        put(32'd2);
        wr(32'h0000_0005, 32'h0000_0005, 32'd0, 32'd0, 0, 1'b0);
        wr(32'h0000_0006, 32'h0000_0006, 32'd0, 32'd0, 1, 1'b1);
        send(32'h0002_0009, edges);
        chk("b2b_hdr_edges", 32'(edges), 32'd2);
        put(32'd1);
        wr(32'h0000_FFFE, 32'hFFFF_FFFE, 32'd2, 32'd9, 0, 1'b1);
        idle(1);

        // Reset mid-frame after 2 of 5 weights
        put(32'h0003_0004);
        put(32'd5);
        wr(32'h0000_0011, 32'h0000_0011, 32'd3, 32'd4, 0, 1'b0);
        wr(32'h0000_0022, 32'h0000_0022, 32'd3, 32'd4, 1, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_weight_valid", 32'(weight_valid), 32'h0);
        chk("mid_rst_weight_value", weight_value, 32'h0);
        chk("mid_rst_layer", config_layer_no, 32'h0);
        chk("mid_rst_neuron", config_neuron_no, 32'h0);
        chk("mid_rst_index", 32'(weight_index), 32'h0);
        chk("mid_rst_load_err", 32'(load_err), 32'h0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        put(32'h0003_0004);
        put(32'd1);
        wr(32'h0000_0033, 32'h0000_0033, 32'd3, 32'd4, 0, 1'b1);
        chk("post_rst_done", 32'(load_done), 32'h1);
        idle(1);

        // Maximum-length frame with random s_valid gaps
        put(32'h000A_000B);
        put(32'd784);
        for (int i = 0; i < 784; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            wr(32'(i), 32'(i), 32'd10, 32'd11, i, (i == 783));
        end
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
